// File: rtl/spmm_pkg.sv
// Shared definitions for the sparse-matrix multiply datapath: index stream
// sequencing states and the index buffer geometry used by bram and its controller.
package spmm_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        EMIT,
        CAP,
        HOLD
    } idx_state_t;

    // Limit a word's lane count to the number of lanes physically present.
    function automatic logic [2:0] clamp_count(input logic [2:0] count,
                                               input int unsigned lanes);
        if (32'(count) > lanes) begin
            return 3'(lanes);
        end
        return count;
    endfunction

endpackage

// File: rtl/index_stream_ctrl.sv
// Sequences the bram index buffer: accepts a packed word of column indices,
// steps bram through lane select / output load, and streams the indices one at
// a time to the multiply stage while counting indices per matrix row.
module index_stream_ctrl #(
    parameter int unsigned LANES = spmm_pkg::LANES,
    parameter int unsigned IDX_W = spmm_pkg::IDX_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [2:0]       word_count,
    input  logic             word_last,
    output logic             bram_index_ready,
    output logic             bram_rw,
    output logic [1:0]       bram_write_ptr,
    input  logic [IDX_W-1:0] bram_index_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_data,
    output logic             idx_last,
    output logic             row_done,
    output logic [CNT_W-1:0] row_len,
    output logic             busy
);
    import spmm_pkg::*;

    idx_state_t       state;
    logic [1:0]       lane;
    logic [2:0]       n;
    logic             last;
    logic [CNT_W-1:0] row_len_cnt;
    logic             out_en;

    logic             accept;
    logic             final_lane;
    logic [2:0]       n_in;
    logic [CNT_W-1:0] cnt_inc;

    // bram controls and word_ready are pure state decodes; idx_ready never reaches them.
    assign word_ready       = out_en && (state == IDLE);
    assign accept           = word_ready && word_valid;
    assign bram_index_ready = accept;
    assign bram_rw          = (state == SEL);
    assign bram_write_ptr   = (state == SEL) ? lane : 2'b00;

    assign n_in       = clamp_count(word_count, LANES);
    assign final_lane = ({1'b0, lane} == (n - 3'd1));
    assign cnt_inc    = (row_len_cnt == '1) ? row_len_cnt : row_len_cnt + CNT_W'(1);

    // Holds word_ready low while reset is asserted and raises it on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    // Main sequencer: word accept, per-lane select/load/capture, downstream handshake, row accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane        <= '0;
            n           <= '0;
            last        <= 1'b0;
            row_len_cnt <= '0;
            idx_valid   <= 1'b0;
            idx_data    <= '0;
            idx_last    <= 1'b0;
            row_done    <= 1'b0;
            row_len     <= '0;
            busy        <= 1'b0;
        end else begin
            row_done <= 1'b0;
            // The count is reported alongside row_done, then cleared one cycle later.
            if (row_done) begin
                row_len_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        n    <= n_in;
                        last <= word_last;
                        lane <= '0;
                        if (n_in != 3'd0) begin
                            state <= SEL;
                            busy  <= 1'b1;
                        end else if (word_last) begin
                            // Empty closing word: the row ends with whatever was already counted.
                            row_done <= 1'b1;
                            row_len  <= row_done ? '0 : row_len_cnt;
                        end
                    end
                end

                SEL: begin
                    state <= EMIT;
                end

                EMIT: begin
                    state <= CAP;
                end

                CAP: begin
                    idx_data  <= bram_index_out;
                    idx_valid <= 1'b1;
                    idx_last  <= last && final_lane;
                    state     <= HOLD;
                end

                HOLD: begin
                    if (idx_ready) begin
                        idx_valid   <= 1'b0;
                        row_len_cnt <= cnt_inc;
                        if (final_lane) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (last) begin
                                row_done <= 1'b1;
                                row_len  <= cnt_inc;
                            end
                        end else begin
                            lane  <= lane + 2'd1;
                            state <= SEL;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/index_stream_ctrl.md
# index_stream_ctrl

Controller that sequences the `bram` index buffer in the sparse-matrix multiply datapath. It accepts one 64-bit word of four packed 16-bit column indices from the memory unit over a valid/ready handshake, then drives the buffer's `indexReady`, `rw` and `writePtr` controls to extract the indices one at a time. The indices go out to the multiply stage as a valid/ready stream. It also tracks row boundaries and reports each row's index count.

## Interface
Parameters:
- `LANES`, 4, indices per memory word.
- `IDX_W`, 16, index width in bits.
- `CNT_W`, 16, width of the row-length counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `word_valid`  in  1  memory unit presents an index word; the data goes directly to the `bram` `indices` input.
- `word_ready`  out  1  controller can accept a word.
- `word_count`  in  3  number of valid lanes in the word, lane 0 first.
- `word_last`  in  1  word is the final one of a matrix row.
- `bram_index_ready`  out  1  drives `bram.indexReady`.
- `bram_rw`  out  1  drives `bram.rw`.
- `bram_write_ptr`  out  2  drives `bram.writePtr`.
- `bram_index_out`  in  IDX_W  from `bram.indexOut`.
- `idx_valid`  out  1  index available downstream.
- `idx_ready`  in  1  downstream accepts the index.
- `idx_data`  out  IDX_W  the index.
- `idx_last`  out  1  final index of the row.
- `row_done`  out  1  single-cycle pulse at row end.
- `row_len`  out  CNT_W  number of indices emitted for the row; valid while `row_done` is high.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEL, EMIT, CAP, HOLD.
- **IDLE**
  - `word_ready`=1, `bram_rw`=0.
  - `bram_index_ready` = `word_valid` (combinational), so the word is latched into `bram` on the accept edge.
  - On accept, register `n` = min(`word_count`, LANES), register `last` = `word_last`, and set `lane`=0.
  - If `n`≠0, go to SEL.
  - If `n`=0 and `last`=1, pulse `row_done` on the next cycle and stay in IDLE.
- **SEL**
  - `bram_rw`=1, `bram_write_ptr`=`lane`, so `ram` loads the selected lane.
  - Go to EMIT.
- **EMIT**
  - `bram_rw`=0, so `indexOut` loads from `ram`.
  - Go to CAP.
- **CAP**
  - `bram_rw`=0.
  - Register `idx_data` ← `bram_index_out`, `idx_valid` ← 1, `idx_last` ← (`last` && `lane`==`n`-1).
  - Go to HOLD.
- **HOLD**
  - `bram_rw`=0, so `indexOut` stays stable.
  - Wait for `idx_ready`. On the handshake: clear `idx_valid`, increment `row_len_cnt`, then:
    - if `lane`==`n`-1, go to IDLE, and if `last`, pulse `row_done`;
    - otherwise `lane`++ and go to SEL.
- **Row accounting**
  - `row_len` presents the count including the final index.
  - The counter clears in the cycle after `row_done`.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- **`word_count` clamping**
  - Values 5–7 are clamped to 4.
- **Handshake rules**
  - `idx_data` and `idx_last` are stable while `idx_valid`=1 and `idx_ready`=0.
  - `idx_valid` never drops without a handshake.
  - `word_ready` is low whenever `busy`=1.
- **Reset**
  - Async reset forces IDLE immediately.
  - All outputs go to 0 except `word_ready`, which goes to 1 after reset release.
  - `lane`, `n`, `last` and `row_len_cnt` reset to 0.
- **Reset mid-row**
  - The partial row is discarded.
  - `bram` has no reset and its stale contents are harmless, because SEL always follows a fresh word load.

## Timing
- Word accept edge E0.
  - SEL occupies cycle 1, EMIT cycle 2, CAP cycle 3.
  - `idx_valid` rises in cycle 4.
- Throughput with `idx_ready` held at 1: one index every 4 cycles, from HOLD through SEL, EMIT and CAP.
- Last lane accepted at edge Ek: `word_ready`=1 and `row_done` (if `last`) in cycle k+1.
- `idx_*`, `row_done`, `row_len` and `busy` are registered.
- `bram_*` controls and `word_ready` are decoded from state, with no combinational path from `idx_ready`.

## Structure
- Shared package `spmm_pkg` holds:
  - the `idx_state_t` enum (IDLE, SEL, EMIT, CAP, HOLD);
  - the LANES and IDX_W constants, which `bram` also uses.
- No sub-module. The parent instantiates `bram` beside this block and wires the `bram_*` ports to it.

## Test plan
The bench instantiates the real `bram`.
1. **Full word, no backpressure.**
   - Stimulus: word 0x0004_0003_0002_0001, count=4, last=0, `idx_ready`=1.
   - Response: indices 0x0001, 0x0002, 0x0003, 0x0004 in order. First `idx_valid` 4 cycles after accept, then every 4 cycles. `idx_last` stays 0. `word_ready` returns in the cycle after the 4th handshake.
2. **Backpressure.**
   - Stimulus: `idx_ready`=0 for 6 cycles on lane 1.
   - Response: `idx_valid`=1 and `idx_data`=0x0002 held constant, `bram_rw` stays 0, no lane advance.
3. **Partial final word.**
   - Stimulus: two words, count=4 then count=2 with last=1.
   - Response: 6 indices, `idx_last` only on the 6th, one `row_done` pulse with `row_len`=6, counter 0 afterwards.
4. **Empty final word.**
   - Stimulus: count=0, last=1, after a 4-index word.
   - Response: no `idx_valid`, `row_done` the cycle after accept, `row_len`=4.
5. **Clamp.**
   - Stimulus: count=7.
   - Response: exactly 4 indices emitted.
6. **Reset mid-row.**
   - Stimulus: `rst_n` low during EMIT of lane 2.
   - Response: outputs 0 immediately, `word_ready`=1 after release, and the next word streams correctly from lane 0.
